// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, latch bit
// positions and the enable/flush patterns the controller drives.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   localparam int STG_IF = 0;
   localparam int STG_ID = 1;
   localparam int STG_AD = 2;
   localparam int STG_EX = 3;
   localparam int NUM_STG = 4;

   // Width of the flush-remaining counter; enough for FLUSH_CYCLES up to 15.
   localparam int REM_W = 4;

   localparam logic [3:0] ENA_ALL     = 4'b1111;
   localparam logic [3:0] ENA_NONE    = 4'b0000;
   localparam logic [3:0] ENA_BACK    = 4'b1100;
   localparam logic [3:0] FLUSH_FRONT = 4'b0011;
   localparam logic [3:0] FLUSH_NONE  = 4'b0000;
   localparam logic [3:0] FLUSH_AD    = 4'b0100;
   localparam logic [3:0] FLUSH_ALL   = 4'b1111;

   function automatic logic [1:0] state_code(input state_t s);
      return 2'(s);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the controller's performance statistics.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         stg_clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge stg_clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: freezes on memory wait, bubbles on load-use and
// redirects fetch with a multi-cycle front-end flush on AD mispredicts.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int PC_W         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             stg_clk,
   input  logic             reset,
   input  logic             ad_valid,
   input  logic             mispredict_ad,
   input  logic             taken_ad,
   input  logic [PC_W-1:0]  pc_target_ad,
   input  logic [PC_W-1:0]  pc_fallthrough_ad,
   input  logic             load_use,
   input  logic             mem_wait,
   output logic [3:0]       stg_ena,
   output logic [3:0]       flush,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] redirect_count
);

   localparam logic [REM_W-1:0] REM_INIT = REM_W'(FLUSH_CYCLES - 1);

   state_t            state_reg, state_next;
   logic [REM_W-1:0]  rem_reg, rem_next;
   logic [PC_W-1:0]   redirect_pc_reg;
   logic [PC_W-1:0]   redirect_target;
   logic [NUM_STG-1:0] stage_held;
   logic              stall_inc;

   assign redirect_target = taken_ad ? pc_target_ad : pc_fallthrough_ad;

   always_ff @(posedge stg_clk) begin
      if (reset) begin
         state_reg <= ST_RUN;
         rem_reg   <= '0;
      end else begin
         state_reg <= state_next;
         rem_reg   <= rem_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      rem_next       = rem_reg;
      stg_ena        = ENA_ALL;
      flush          = FLUSH_NONE;
      redirect_valid = 1'b0;

      case (state_reg)
         ST_RUN: begin
            if (mem_wait) begin
               stg_ena    = ENA_NONE;
               state_next = ST_MEM_WAIT;
            end else if (ad_valid && mispredict_ad) begin
               flush          = FLUSH_FRONT;
               redirect_valid = 1'b1;
               // The redirect cycle itself is the first of the flush cycles.
               if (FLUSH_CYCLES == 1) begin
                  state_next = ST_RUN;
                  rem_next   = '0;
               end else begin
                  state_next = ST_FLUSH;
                  rem_next   = REM_INIT;
               end
            end else if (load_use) begin
               stg_ena = ENA_BACK;
               flush   = FLUSH_AD;
            end
         end

         ST_MEM_WAIT: begin
            stg_ena = ENA_NONE;
            if (!mem_wait) begin
               state_next = ST_RUN;
            end
         end

         ST_FLUSH: begin
            if (mem_wait) begin
               stg_ena = ENA_NONE;
            end else begin
               flush = FLUSH_FRONT;
               if (rem_reg <= REM_W'(1)) begin
                  state_next = ST_RUN;
                  rem_next   = '0;
               end else begin
                  rem_next = rem_reg - REM_W'(1);
               end
            end
         end

         default: begin
            stg_ena    = ENA_NONE;
            state_next = ST_RUN;
            rem_next   = '0;
         end
      endcase

      // Reset overrides everything: freeze all latches and load bubbles.
      if (reset) begin
         stg_ena        = ENA_NONE;
         flush          = FLUSH_ALL;
         redirect_valid = 1'b0;
      end
   end

   always_ff @(posedge stg_clk) begin
      if (reset) begin
         redirect_pc_reg <= '0;
      end else if (redirect_valid) begin
         redirect_pc_reg <= redirect_target;
      end
   end

   // Fresh target is visible in the redirect cycle; the register holds it after.
   assign redirect_pc = redirect_valid ? redirect_target : redirect_pc_reg;
   assign state       = state_code(state_reg);

   for (genvar gi = 0; gi < NUM_STG; gi++) begin : g_held
      assign stage_held[gi] = ~stg_ena[gi] | flush[gi];
   end

   assign stall_inc = |stage_held;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .stg_clk (stg_clk),
      .reset   (reset),
      .inc     (stall_inc),
      .count   (stall_count)
   );

   sat_counter #(.W(CNT_W)) u_redirect_cnt (
      .stg_clk (stg_clk),
      .reset   (reset),
      .inc     (redirect_valid),
      .count   (redirect_count)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table driven through a scoreboard
// queue, plus a hand-written mem_wait/redirect latency sequence.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic        stg_clk = 1'b0;
   logic        reset;
   logic        ad_valid, mispredict_ad, taken_ad, load_use, mem_wait;
   logic [31:0] pc_target_ad, pc_fallthrough_ad;
   logic [3:0]  stg_ena, flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [1:0]  state;
   logic [15:0] stall_count, redirect_count;

   always #5 stg_clk = ~stg_clk;

   pipe_ctrl #(.PC_W(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .stg_clk           (stg_clk),
      .reset             (reset),
      .ad_valid          (ad_valid),
      .mispredict_ad     (mispredict_ad),
      .taken_ad          (taken_ad),
      .pc_target_ad      (pc_target_ad),
      .pc_fallthrough_ad (pc_fallthrough_ad),
      .load_use          (load_use),
      .mem_wait          (mem_wait),
      .stg_ena           (stg_ena),
      .flush             (flush),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .state             (state),
      .stall_count       (stall_count),
      .redirect_count    (redirect_count)
   );

   typedef struct {
      logic        rst, adv, mis, tkn, lu, mw;
      logic [31:0] tgt, fall;
      logic [3:0]  ena, fl;
      logic        rv;
      logic [1:0]  st;
   } vec_t;

   typedef struct {
      int          idx;
      logic [3:0]  ena, fl;
      logic        rv;
      logic [1:0]  st;
      logic [31:0] pc;
      logic [15:0] stall, redir;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [31:0] m_pc;
   logic [15:0] m_stall, m_redir;

   task automatic add(input logic rst, adv, mis, tkn, input logic [31:0] tgt, fall,
                      input logic lu, mw, input logic [3:0] ena, fl,
                      input logic rv, input logic [1:0] st);
      vec_t v;
      v.rst = rst; v.adv = adv; v.mis = mis; v.tkn = tkn; v.tgt = tgt; v.fall = fall;
      v.lu = lu; v.mw = mw; v.ena = ena; v.fl = fl; v.rv = rv; v.st = st;
      vecs.push_back(v);
   endtask

   task automatic add_idle(input logic [3:0] fl, input logic [1:0] st);
      add(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 4'b1111, fl, 0, st);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset             = v.rst;
      ad_valid          = v.adv;
      mispredict_ad     = v.mis;
      taken_ad          = v.tkn;
      pc_target_ad      = v.tgt;
      pc_fallthrough_ad = v.fall;
      load_use          = v.lu;
      mem_wait          = v.mw;
   endtask

   initial begin
      vec_t v;
      exp_t e;
      int   k, lat;
      logic seen;

      // Reset with every hazard input asserted; outputs must still be reset values.
      add(1, 1, 1, 1, 32'h900, 32'h904, 1, 1, 4'b0000, 4'b1111, 0, 0);
      repeat (10) add_idle(4'b0000, 0);
      // Resolved branch without mispredict, and mispredict without valid: no action.
      add(0, 1, 0, 1, 32'h180, 32'h104, 0, 0, 4'b1111, 4'b0000, 0, 0);
      add(0, 0, 1, 1, 32'h180, 32'h104, 0, 0, 4'b1111, 4'b0000, 0, 0);
      // Taken redirect, flush cycle ignores a new mispredict, then RUN.
      add(0, 1, 1, 1, 32'h100, 32'h204, 0, 0, 4'b1111, 4'b0011, 1, 0);
      add(0, 1, 1, 0, 32'h700, 32'h704, 0, 0, 4'b1111, 4'b0011, 0, 2);
      add_idle(4'b0000, 0);
      // Not-taken redirect uses the fall-through; load_use ignored while flushing.
      add(0, 1, 1, 0, 32'h300, 32'h404, 0, 0, 4'b1111, 4'b0011, 1, 0);
      add(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 4'b1111, 4'b0011, 0, 2);
      add_idle(4'b0000, 0);
      // Clear counters, then load_use for three cycles.
      add(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 4'b0000, 4'b1111, 0, 0);
      repeat (3) add(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 4'b1100, 4'b0100, 0, 0);
      add_idle(4'b0000, 0);
      // mem_wait + mispredict + load_use: freeze, then redirect after release.
      add(0, 1, 1, 1, 32'h500, 32'h504, 1, 1, 4'b0000, 4'b0000, 0, 0);
      add(0, 1, 1, 1, 32'h500, 32'h504, 1, 1, 4'b0000, 4'b0000, 0, 1);
      add(0, 1, 1, 1, 32'h500, 32'h504, 1, 0, 4'b0000, 4'b0000, 0, 1);
      add(0, 1, 1, 1, 32'h500, 32'h504, 1, 0, 4'b1111, 4'b0011, 1, 0);
      add_idle(4'b0011, 2);
      add_idle(4'b0000, 0);
      // mem_wait for 4 cycles during FLUSH: remaining held, one flush after.
      add(0, 1, 1, 1, 32'h600, 32'h604, 0, 0, 4'b1111, 4'b0011, 1, 0);
      repeat (4) add(0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 4'b0000, 4'b0000, 0, 2);
      add_idle(4'b0011, 2);
      add_idle(4'b0000, 0);
      // Reset during FLUSH.
      add(0, 1, 1, 1, 32'h700, 32'h704, 0, 0, 4'b1111, 4'b0011, 1, 0);
      add(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 4'b0000, 4'b1111, 0, 2);
      add(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 4'b0000, 4'b1111, 0, 0);
      add_idle(4'b0000, 0);
      // Reset during MEM_WAIT, then a plain mem_wait exit.
      add(0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 4'b0000, 4'b0000, 0, 0);
      add(1, 0, 0, 0, 32'h0, 32'h0, 0, 1, 4'b0000, 4'b1111, 0, 1);
      add_idle(4'b0000, 0);
      add(0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 4'b0000, 4'b0000, 0, 0);
      add(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 4'b0000, 4'b0000, 0, 1);
      add_idle(4'b0000, 0);

      // Initial reset edge so registered outputs are defined.
      v = vecs[0];
      drive(v);
      m_pc = '0; m_stall = '0; m_redir = '0;
      @(posedge stg_clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         drive(v);
         e.idx   = i;
         e.ena   = v.ena;
         e.fl    = v.fl;
         e.rv    = v.rv;
         e.st    = v.st;
         e.pc    = v.rv ? (v.tkn ? v.tgt : v.fall) : m_pc;
         e.stall = m_stall;
         e.redir = m_redir;
         sb.push_back(e);
         if (v.rst) begin
            m_pc = '0; m_stall = '0; m_redir = '0;
         end else begin
            if (v.rv) m_pc = e.pc;
            if (((v.ena != 4'b1111) || (v.fl != 4'b0000)) && (m_stall != 16'hFFFF)) m_stall++;
            if (v.rv && (m_redir != 16'hFFFF)) m_redir++;
         end

         @(negedge stg_clk);
         e = sb.pop_front();
         check("stg_ena", e.idx, 32'(stg_ena), 32'(e.ena));
         check("flush", e.idx, 32'(flush), 32'(e.fl));
         check("redirect_valid", e.idx, 32'(redirect_valid), 32'(e.rv));
         check("state", e.idx, 32'(state), 32'(e.st));
         check("redirect_pc", e.idx, redirect_pc, e.pc);
         check("stall_count", e.idx, 32'(stall_count), 32'(e.stall));
         check("redirect_count", e.idx, 32'(redirect_count), 32'(e.redir));
         $display("[TB] step %0d rst=%0b adv=%0b mis=%0b lu=%0b mw=%0b -> ena=%b flush=%b rv=%0b st=%0d pc=%0h",
                  i, v.rst, v.adv, v.mis, v.lu, v.mw, stg_ena, flush, redirect_valid, state, redirect_pc);
         @(posedge stg_clk); #1;
      end

      // Random-length mem_wait with a pending mispredict: redirect exactly one
      // cycle after the MEM_WAIT exit cycle.
      k = $urandom_range(2, 6);
      reset = 0; ad_valid = 1; mispredict_ad = 1; taken_ad = 0; load_use = 1;
      pc_target_ad = 32'h999; pc_fallthrough_ad = 32'h888; mem_wait = 1;
      for (int j = 0; j < k; j++) begin
         @(negedge stg_clk);
         check("mw_hold_ena", 100 + j, 32'(stg_ena), 32'(4'b0000));
         check("mw_hold_rv", 100 + j, 32'(redirect_valid), 32'(1'b0));
         @(posedge stg_clk); #1;
      end
      mem_wait = 0;
      seen = 0; lat = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge stg_clk);
         if (redirect_valid) begin
            seen = 1; lat = c;
            check("mw_redirect_pc", 200, redirect_pc, 32'h888);
         end
         @(posedge stg_clk); #1;
         if (seen) break;
      end
      ad_valid = 0; mispredict_ad = 0; load_use = 0;
      check("mw_redirect_seen", 201, 32'(seen), 32'(1'b1));
      check("mw_redirect_latency", 202, 32'(lat), 32'd1);
      check("mw_redirect_count", 203, 32'(redirect_count), 32'(m_redir + 16'd1));
      $display("[TB] mem_wait hold %0d cycles, redirect latency %0d, redirect_count %0d", k, lat, redirect_count);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
